// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the machine-mode trap controller
// Purpose: state enum, CSR addresses, mcause codes and mstatus/mie bit positions
//          used by trap_ctrl.
// Ports:   none (package).
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_STATUS,
    ST_MRET_STATUS,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // 32-bit encodings; bit 31 is the interrupt flag and is moved to XLEN-1 by the user.
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] MCAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_MEI     = 32'h8000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - flop-chain synchronizer for an asynchronous level input
// Purpose: brings an asynchronous interrupt level into the clk domain.
// Ports:   clk   system clock
//          rst   asynchronous active-high reset, clears every stage
//          d     asynchronous input level
//          q     synchronized level, STAGES cycles behind d
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / MRET exit sequencer and CSR write-port owner
// Purpose: detects illegal-instruction exceptions and pending timer/external
//          interrupts, flushes and stalls the pipeline, writes mepc, mcause and
//          mstatus through the single CSR write port, then redirects the PC to
//          the trap vector (or to mepc on MRET).
// Optional: define TRAP_VECTORED_EN to honour mtvec vectored mode for interrupts.
// Ports:   clk, rst                       clock, asynchronous active-high reset
//          irq_timer, irq_ext             MTIP (synchronous), MEIP (asynchronous)
//          illegal_inst, is_mret,
//          ex_valid, ex_pc                EX-stage status and PC
//          mstatus_q, mie_q, mepc_q,
//          mtvec_q                        current CSR values
//          pipe_csr_wr/addr/wdata         pipeline CSR write request
//          csr_we/addr/wdata              muxed CSR write port
//          pipe_stall, pipe_flush         pipeline control
//          pc_redirect, redirect_pc       PC load request and target
module trap_ctrl #(
  parameter int XLEN            = 32,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic            illegal_inst,
  input  logic            is_mret,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mie_q,
  input  logic [XLEN-1:0] mepc_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic            pipe_csr_wr,
  input  logic [11:0]     pipe_csr_addr,
  input  logic [XLEN-1:0] pipe_csr_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            pipe_stall,
  output logic            pipe_flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc
);

  import trap_pkg::*;

  trap_state_e     state, next_state;
  logic [XLEN-1:0] epc_q, cause_q, target_q;
  logic            irq_ext_sync;
  logic            exc, ext, tmr, take;
  logic [XLEN-1:0] take_cause;
  logic [XLEN-1:0] tvec_base, trap_target;
  logic [XLEN-1:0] status_trap, status_mret;

  // Relocate the interrupt flag of a 32-bit mcause encoding to bit XLEN-1.
  function automatic logic [XLEN-1:0] xcause(input logic [31:0] c);
    logic [XLEN-1:0] r;
    r           = '0;
    r[30:0]     = c[30:0];
    r[XLEN-1]   = c[31];
    return r;
  endfunction

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_ext),
    .q   (irq_ext_sync)
  );

  assign exc  = ex_valid & illegal_inst;
  assign ext  = irq_ext_sync & mie_q[MIE_MEIE] & mstatus_q[MSTATUS_MIE];
  assign tmr  = irq_timer & mie_q[MIE_MTIE] & mstatus_q[MSTATUS_MIE];
  assign take = exc | ext | tmr;

  assign take_cause = exc ? xcause(MCAUSE_ILLEGAL) :
                      ext ? xcause(MCAUSE_MEI)     :
                            xcause(MCAUSE_MTI);

  always_comb begin
    status_trap                                = mstatus_q;
    status_trap[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]                   = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    status_mret               = mstatus_q;
    status_mret[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
  end

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode only offsets interrupts; exceptions always land on base.
  assign trap_target = (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ?
                       tvec_base + XLEN'({cause_q[4:0], 2'b00}) : tvec_base;
`else
  assign trap_target = tvec_base;
`endif

  logic unused_bits;
  assign unused_bits = ^{mie_q, mtvec_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && take) begin
        epc_q   <= ex_pc;
        cause_q <= take_cause;
      end
      if (state == ST_SAVE_STATUS) begin
        target_q <= trap_target;
      end
      if (state == ST_MRET_STATUS) begin
        target_q <= mepc_q;
      end
    end
  end

  always_comb begin
    next_state  = state;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    pipe_stall  = 1'b0;
    pipe_flush  = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;

    case (state)
      ST_IDLE: begin
        if (take) begin
          // The EX instruction is killed, so its CSR write is dropped.
          pipe_stall = 1'b1;
          pipe_flush = 1'b1;
          next_state = ST_SAVE_EPC;
        end else if (ex_valid && is_mret) begin
          pipe_stall = 1'b1;
          next_state = ST_MRET_STATUS;
        end else begin
          csr_we    = pipe_csr_wr;
          csr_addr  = pipe_csr_addr;
          csr_wdata = pipe_csr_wdata;
        end
      end
      ST_SAVE_EPC: begin
        csr_we     = 1'b1;
        csr_addr   = CSR_MEPC;
        csr_wdata  = epc_q;
        pipe_stall = 1'b1;
        next_state = ST_SAVE_CAUSE;
      end
      ST_SAVE_CAUSE: begin
        csr_we     = 1'b1;
        csr_addr   = CSR_MCAUSE;
        csr_wdata  = cause_q;
        pipe_stall = 1'b1;
        next_state = ST_SAVE_STATUS;
      end
      ST_SAVE_STATUS: begin
        csr_we     = 1'b1;
        csr_addr   = CSR_MSTATUS;
        csr_wdata  = status_trap;
        pipe_stall = 1'b1;
        next_state = ST_REDIRECT;
      end
      ST_MRET_STATUS: begin
        csr_we     = 1'b1;
        csr_addr   = CSR_MSTATUS;
        csr_wdata  = status_mret;
        pipe_stall = 1'b1;
        next_state = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = target_q;
        pipe_stall  = 1'b1;
        pipe_flush  = 1'b1;
        next_state  = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, including the passthrough.
    if (rst) begin
      csr_we      = 1'b0;
      csr_addr    = '0;
      csr_wdata   = '0;
      pipe_stall  = 1'b0;
      pipe_flush  = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl with a queue-based reference model
module tb_trap_ctrl;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_TMR_RPC = 32'h0000_011C;
`else
  localparam logic [31:0] VEC_TMR_RPC = 32'h0000_0100;
`endif

  localparam int K_EPC = 0, K_CAUSE = 1, K_STATUS = 2, K_MRET = 3, K_REDIR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            irq_timer, irq_ext, illegal_inst, is_mret, ex_valid;
  logic [XLEN-1:0] ex_pc, mstatus_q, mie_q, mepc_q, mtvec_q;
  logic            pipe_csr_wr;
  logic [11:0]     pipe_csr_addr;
  logic [XLEN-1:0] pipe_csr_wdata;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            pipe_stall, pipe_flush, pc_redirect;
  logic [XLEN-1:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  trap_ctrl #(.XLEN(XLEN), .IRQ_SYNC_STAGES(STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_timer      (irq_timer),
    .irq_ext        (irq_ext),
    .illegal_inst   (illegal_inst),
    .is_mret        (is_mret),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .mstatus_q      (mstatus_q),
    .mie_q          (mie_q),
    .mepc_q         (mepc_q),
    .mtvec_q        (mtvec_q),
    .pipe_csr_wr    (pipe_csr_wr),
    .pipe_csr_addr  (pipe_csr_addr),
    .pipe_csr_wdata (pipe_csr_wdata),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int              mq[$];
  logic [3:0]      hist = '0;   // hist[0] = irq_ext of the previous cycle
  logic [31:0]     m_epc, m_cause, m_target;

  function automatic logic [31:0] trap_status(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] m);
    return (m & ~32'h0000_0088) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] vec_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (tvec[1:0] == 2'b01 && cause[31]) return base + 4 * cause[4:0];
`endif
    return base;
  endfunction

  always @(negedge clk) begin
    logic        e_we, e_st, e_fl, e_rd, take, es;
    logic [11:0] e_ad;
    logic [31:0] e_wd, e_pc, mc;
    int          k;
    e_we = 0; e_ad = 0; e_wd = 0; e_st = 0; e_fl = 0; e_rd = 0; e_pc = 0;
    take = 0; mc = 0;
    if (rst) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      es = hist[STAGES-1];
      if (ex_valid && illegal_inst) begin take = 1; mc = 32'h2; end
      else if (es && mie_q[11] && mstatus_q[3]) begin take = 1; mc = 32'h8000_000B; end
      else if (irq_timer && mie_q[7] && mstatus_q[3]) begin take = 1; mc = 32'h8000_0007; end
      if (take) begin
        e_st = 1; e_fl = 1;
        m_epc = ex_pc; m_cause = mc;
        mq.push_back(K_EPC); mq.push_back(K_CAUSE);
        mq.push_back(K_STATUS); mq.push_back(K_REDIR);
      end else if (ex_valid && is_mret) begin
        e_st = 1;
        mq.push_back(K_MRET); mq.push_back(K_REDIR);
      end else begin
        e_we = pipe_csr_wr; e_ad = pipe_csr_addr; e_wd = pipe_csr_wdata;
      end
    end else begin
      k = mq.pop_front();
      e_st = 1;
      case (k)
        K_EPC:    begin e_we = 1; e_ad = 12'h341; e_wd = m_epc; end
        K_CAUSE:  begin e_we = 1; e_ad = 12'h342; e_wd = m_cause; end
        K_STATUS: begin e_we = 1; e_ad = 12'h300; e_wd = trap_status(mstatus_q);
                        m_target = vec_target(mtvec_q, m_cause); end
        K_MRET:   begin e_we = 1; e_ad = 12'h300; e_wd = mret_status(mstatus_q);
                        m_target = mepc_q; end
        default:  begin e_rd = 1; e_fl = 1; e_pc = m_target; end
      endcase
    end
    checks++;
    if ({csr_we, csr_addr, csr_wdata, pipe_stall, pipe_flush, pc_redirect, redirect_pc} !==
        {e_we, e_ad, e_wd, e_st, e_fl, e_rd, e_pc}) begin
      failures++;
      $display("FAIL cycle_model t=%0t got we=%b addr=%h wdata=%h st=%b fl=%b rd=%b rpc=%h exp we=%b addr=%h wdata=%h st=%b fl=%b rd=%b rpc=%h",
               $time, csr_we, csr_addr, csr_wdata, pipe_stall, pipe_flush, pc_redirect, redirect_pc,
               e_we, e_ad, e_wd, e_st, e_fl, e_rd, e_pc);
    end
    if (rst) hist = '0;
    else     hist = {hist[2:0], irq_ext};
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    irq_timer = 0; irq_ext = 0; illegal_inst = 0; is_mret = 0; ex_valid = 0;
    ex_pc = 0; mstatus_q = 0; mie_q = 0; mepc_q = 0; mtvec_q = 0;
    pipe_csr_wr = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0;
  endtask

  task automatic do_reset();
    adv();
    rst = 1;
    clear_inputs();
    adv();
    rst = 0;
  endtask

  // Inputs for cycle T are already driven; walks the full trap sequence.
  task automatic trap_seq(input string tag, input logic [31:0] x_epc, input logic [31:0] x_cause,
                          input logic [31:0] x_status, input logic [31:0] x_rpc);
    sample();
    chk({tag, "_flush_T"}, {31'b0, pipe_flush}, 1);
    chk({tag, "_we_T"}, {31'b0, csr_we}, 0);
    adv();
    irq_timer = 0; irq_ext = 0; illegal_inst = 0; ex_valid = 0; pipe_csr_wr = 0;
    sample();
    chk({tag, "_epc_addr"}, {20'b0, csr_addr}, 32'h341);
    chk({tag, "_epc_data"}, csr_wdata, x_epc);
    adv(); sample();
    chk({tag, "_cause_addr"}, {20'b0, csr_addr}, 32'h342);
    chk({tag, "_cause_data"}, csr_wdata, x_cause);
    adv(); sample();
    chk({tag, "_status_addr"}, {20'b0, csr_addr}, 32'h300);
    chk({tag, "_status_data"}, csr_wdata, x_status);
    adv(); sample();
    chk({tag, "_redirect"}, {31'b0, pc_redirect}, 1);
    chk({tag, "_rpc"}, redirect_pc, x_rpc);
    adv(); sample();
    chk({tag, "_stall_after"}, {31'b0, pipe_stall}, 0);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    pipe_csr_wr = 1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h55;
    sample();
    chk("reset_we", {31'b0, csr_we}, 0);
    chk("reset_stall", {31'b0, pipe_stall}, 0);
    adv();
    rst = 0;

    // Timer interrupt, direct mode.
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h80; mtvec_q = 32'h100; ex_pc = 32'h40;
    ex_valid = 1; irq_timer = 1;
    trap_seq("tmr", 32'h40, 32'h8000_0007, 32'h1880, 32'h100);

    // Timer with vectored mtvec, then illegal instruction with the same mtvec.
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h80; mtvec_q = 32'h101; ex_pc = 32'h40;
    ex_valid = 1; irq_timer = 1;
    trap_seq("tmr_vec", 32'h40, 32'h8000_0007, 32'h1880, VEC_TMR_RPC);
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h80; mtvec_q = 32'h101; ex_pc = 32'h40;
    ex_valid = 1; illegal_inst = 1;
    trap_seq("ill_vec", 32'h40, 32'h2, 32'h1880, 32'h100);

    // MRET.
    do_reset();
    mstatus_q = 32'h80; mepc_q = 32'h44; ex_valid = 1; is_mret = 1;
    sample();
    chk("mret_stall_T", {31'b0, pipe_stall}, 1);
    chk("mret_flush_T", {31'b0, pipe_flush}, 0);
    adv(); is_mret = 0; ex_valid = 0;
    sample();
    chk("mret_addr", {20'b0, csr_addr}, 32'h300);
    chk("mret_data", csr_wdata, 32'h88);
    adv(); sample();
    chk("mret_rpc", redirect_pc, 32'h44);
    chk("mret_redirect", {31'b0, pc_redirect}, 1);
    adv(); sample();
    chk("mret_stall_after", {31'b0, pipe_stall}, 0);

    // External interrupt latency through the synchronizer.
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h800; mtvec_q = 32'h100; ex_pc = 32'h80; irq_ext = 1;
    for (int i = 0; i < STAGES; i++) begin
      sample();
      chk("ext_early_flush", {31'b0, pipe_flush}, 0);
      adv();
    end
    trap_seq("ext_late", 32'h80, 32'h8000_000B, 32'h1880, 32'h100);

    // External and timer both pending: external wins.
    do_reset();
    mstatus_q = 32'h0; mie_q = 32'h880; mtvec_q = 32'h200; ex_pc = 32'h60;
    irq_ext = 1; irq_timer = 1;
    for (int i = 0; i < STAGES; i++) begin sample(); adv(); end
    mstatus_q = 32'h8;
    trap_seq("ext_tmr", 32'h60, 32'h8000_000B, 32'h1880, 32'h200);

    // Exception beats timer and kills the pipeline CSR write.
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h80; mtvec_q = 32'h100; ex_pc = 32'h90;
    ex_valid = 1; illegal_inst = 1; irq_timer = 1;
    pipe_csr_wr = 1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h1234;
    trap_seq("exc_prio", 32'h90, 32'h2, 32'h1880, 32'h100);

    // Reset in SAVE_CAUSE.
    do_reset();
    mstatus_q = 32'h8; mie_q = 32'h80; mtvec_q = 32'h100; ex_pc = 32'h40;
    ex_valid = 1; irq_timer = 1;
    sample();
    chk("rstmid_flush_T", {31'b0, pipe_flush}, 1);
    adv(); irq_timer = 0; ex_valid = 0;
    sample();
    chk("rstmid_epc_addr", {20'b0, csr_addr}, 32'h341);
    adv();
    rst = 1;
    #1;
    chk("rstmid_we", {31'b0, csr_we}, 0);
    chk("rstmid_stall", {31'b0, pipe_stall}, 0);
    sample();
    chk("rstmid_no_status", {31'b0, csr_we}, 0);
    adv();
    rst = 0;
    pipe_csr_wr = 1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'hABC;
    sample();
    chk("rstmid_pass_we", {31'b0, csr_we}, 1);
    chk("rstmid_pass_addr", {20'b0, csr_addr}, 32'h305);
    chk("rstmid_pass_data", csr_wdata, 32'hABC);
    chk("rstmid_pass_stall", {31'b0, pipe_stall}, 0);

    // Randomized phase, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      adv();
      rst            = ($urandom_range(0, 249) == 0);
      irq_timer      = ($urandom_range(0, 7) == 0);
      irq_ext        = ($urandom_range(0, 7) == 0);
      illegal_inst   = ($urandom_range(0, 7) == 0);
      is_mret        = ($urandom_range(0, 5) == 0);
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_pc          = $urandom & ~32'h3;
      mstatus_q      = $urandom;
      mie_q          = $urandom;
      mepc_q         = $urandom & ~32'h3;
      mtvec_q        = ($urandom_range(0, 1) == 0) ? (($urandom & ~32'h3) | 32'h1) : $urandom;
      pipe_csr_wr    = $urandom_range(0, 1);
      pipe_csr_addr  = 12'($urandom);
      pipe_csr_wdata = $urandom;
    end
    adv();
    rst = 0;
    clear_inputs();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET exit for the 3-stage pipeline.
- Detects pending interrupts and illegal-instruction exceptions, stalls and flushes the pipeline, and performs the mepc/mcause/mstatus updates through the single CSR write port.
- Redirects the PC to the trap vector on entry, or to mepc on MRET.
- Owns the CSR write port: it muxes the pipeline's CSR-instruction writes with its own sequenced writes.

Parameters:
- XLEN, 32, data/PC width.
- IRQ_SYNC_STAGES, 2, flop stages synchronizing irq_ext; legal range 2..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- irq_timer  in  1  machine timer pending (MTIP); synchronous to clk
- irq_ext  in  1  machine external pending (MEIP); asynchronous, synchronized internally
- illegal_inst  in  1  decoder flags illegal instruction in EX
- is_mret  in  1  MRET in EX
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  XLEN  PC of EX instruction
- mstatus_q  in  XLEN  current mstatus
- mie_q  in  XLEN  current mie
- mepc_q  in  XLEN  current mepc
- mtvec_q  in  XLEN  current mtvec
- pipe_csr_wr  in  1  pipeline CSR write request
- pipe_csr_addr  in  12  pipeline CSR address
- pipe_csr_wdata  in  XLEN  pipeline CSR write data
- csr_we  out  1  CSR write enable
- csr_addr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- pipe_stall  out  1  freeze fetch/decode/EX
- pipe_flush  out  1  kill the EX instruction this cycle
- pc_redirect  out  1  load redirect_pc into PC
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: async; all outputs 0, FSM to IDLE, latched epc/cause/target cleared, synchronizer flops cleared. A reset mid-sequence abandons it with no further CSR writes.
- Take conditions, evaluated in IDLE, highest priority first:
  - exc = ex_valid & illegal_inst; cause 0x00000002.
  - ext = irq_ext_sync & mie_q[11] & mstatus_q[3]; cause 0x8000000B.
  - tmr = irq_timer & mie_q[7] & mstatus_q[3]; cause 0x80000007.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT.
- IDLE, trap taken:
  - Latch epc = ex_pc and the cause.
  - Assert pipe_flush and pipe_stall this cycle.
  - Drop any pipe_csr_wr this cycle (instruction killed).
  - Next state SAVE_EPC.
- IDLE, no trap, ex_valid & is_mret: assert pipe_stall; next state MRET_STATUS. A pending interrupt outranks MRET: MRET is flushed and becomes the epc.
- IDLE, otherwise: pass pipe_csr_wr/addr/wdata straight to csr_we/addr/wdata (combinational); stall 0.
- SAVE_EPC: csr_we=1, addr 0x341, wdata=latched epc.
- SAVE_CAUSE: csr_we=1, addr 0x342, wdata=latched cause.
- SAVE_STATUS: csr_we=1, addr 0x300, wdata=mstatus_q with bit7(MPIE)=bit3(MIE), bit3=0, bits[12:11]=2'b11. Target = {mtvec_q[XLEN-1:2],2'b00}.
- MRET_STATUS: csr_we=1, addr 0x300, wdata=mstatus_q with bit3=bit7, bit7=1. Target = mepc_q.
- REDIRECT: pc_redirect=1, redirect_pc=target, pipe_stall=1, pipe_flush=1; next state IDLE. Stall drops the following cycle.
- pipe_stall=1 in every non-IDLE state. Pipeline writes are ignored outside IDLE.
- Latency:
  - Trap detected at cycle T; writes at T+1..T+3; redirect at T+4.
  - MRET detected at T; write at T+1; redirect at T+2.
- Interrupt/exception inputs are ignored outside IDLE. No re-trap occurs after entry because MIE was cleared; illegal_inst during the sequence is masked by the stall.
- irq_ext passes through an IRQ_SYNC_STAGES flop chain before use; irq_timer is used directly.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when mtvec_q[1:0]==2'b01 and the cause is an interrupt, target = base + 4*cause[4:0] (timer base+0x1C, external base+0x2C). Exceptions still use base.
- Undefined: mtvec mode bits ignored; target always base.

Decomposition:
- Package trap_pkg holds:
  - state enum trap_state_e.
  - CSR addresses CSR_MSTATUS=0x300, CSR_MIE=0x304, CSR_MTVEC=0x305, CSR_MEPC=0x341, CSR_MCAUSE=0x342.
  - mcause codes MCAUSE_ILLEGAL, MCAUSE_MTI, MCAUSE_MEI.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11; mie bit indices MTIE=7, MEIE=11.
- Sub-module irq_sync: parameterized flop-chain synchronizer with async reset.

Test Plan:
- mstatus=0x8, mie=0x80, mtvec=0x100, ex_pc=0x40, irq_timer=1 → flush at T; writes 0x341←0x40, 0x342←0x80000007, 0x300←0x1880; redirect_pc=0x100 at T+4.
- Same with TRAP_VECTORED_EN, mtvec=0x101 → redirect_pc=0x11C; illegal_inst with the same mtvec → redirect_pc=0x100, mcause 0x2.
- mstatus=0x80, mepc=0x44, is_mret & ex_valid → 0x300←0x88 at T+1; redirect_pc=0x44 at T+2; stall low at T+3.
- irq_ext and irq_timer both pending, both enabled → irq_ext reaches the take logic IRQ_SYNC_STAGES cycles late; mcause=0x8000000B.
- illegal_inst plus pending timer and pipe_csr_wr in the same cycle → exception wins (cause 0x2); pipeline write not issued.
- rst asserted in SAVE_CAUSE → all outputs 0 immediately; no 0x300 write; IDLE after release with pipe_csr_wr passthrough working.
